// File: rtl/mod_inverse_ctrl_pkg.sv
// Shared types for the modular-inverse controller: FSM states, coefficient width
// and the (old_r, r, old_s, s) Euclid tuple carried between steps.
package mod_inv_pkg;

  localparam int MOD_INV_WIDTH = 32;

  function automatic int coeff_w(input int word_w);
    return word_w + 1;
  endfunction

  localparam int COEFF_W = coeff_w(MOD_INV_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } state_e;

  // One extra coefficient bit keeps |s| <= n representable as a signed value.
  typedef struct packed {
    logic        [MOD_INV_WIDTH-1:0] old_r;
    logic        [MOD_INV_WIDTH-1:0] r;
    logic signed [COEFF_W-1:0]       old_s;
    logic signed [COEFF_W-1:0]       s;
  } egcd_t;

endpackage

// File: rtl/mod_inverse_ctrl_if.sv
// Request/result bundle of the modular-inverse controller.
// start_i is a request sampled only while idle; done_o is a one-cycle strobe and
// inv_o/error_o stay valid from that strobe until the next completion.
interface mod_inverse_ctrl_if #(
  parameter int WORD_WIDTH = 32
);
  logic                  start_i;
  logic [WORD_WIDTH-1:0] a_i;
  logic [WORD_WIDTH-1:0] n_i;
  logic                  busy_o;
  logic                  done_o;
  logic [WORD_WIDTH-1:0] inv_o;
  logic                  error_o;

  modport master (
    output start_i, a_i, n_i,
    input  busy_o, done_o, inv_o, error_o
  );

  modport slave (
    input  start_i, a_i, n_i,
    output busy_o, done_o, inv_o, error_o
  );
endinterface

// File: rtl/mod_inverse_ctrl_egcd_step.sv
// One combinational extended-Euclid step: next tuple plus a flag for a zero remainder.
module egcd_step
  import mod_inv_pkg::*;
(
  input  egcd_t cur_i,
  output egcd_t nxt_o,
  output logic  r_zero_o
);
  localparam int W = MOD_INV_WIDTH;

  logic        [W-1:0]       divisor;
  logic        [W-1:0]       q;
  logic        [W-1:0]       rem;
  logic signed [COEFF_W-1:0] q_times_s;

  always_comb begin
    // r is never zero while iterating; the guard only keeps idle cycles well defined.
    divisor   = (cur_i.r == '0) ? W'(1) : cur_i.r;
    q         = cur_i.old_r / divisor;
    rem       = cur_i.old_r % divisor;
    q_times_s = $signed({1'b0, q}) * cur_i.s;
    nxt_o.old_r = cur_i.r;
    nxt_o.r     = rem;
    nxt_o.old_s = cur_i.s;
    nxt_o.s     = cur_i.old_s - q_times_s;
    r_zero_o    = (rem == '0);
  end
endmodule

// File: rtl/mod_inverse_ctrl.sv
// Modular inverse a^-1 mod n by extended Euclid, one step per clock.
// Optional iteration limit: define MOD_INV_TIMEOUT_EN (limit given by MAX_ITER).
module mod_inverse_ctrl
  import mod_inv_pkg::*;
#(
  parameter int WORD_WIDTH = MOD_INV_WIDTH
`ifdef MOD_INV_TIMEOUT_EN
  , parameter int MAX_ITER = 64
`endif
) (
  input  logic               clk,
  input  logic               rst,
  mod_inverse_ctrl_if.slave  bus,
  output state_e             dbg_state_o
);
  localparam int W = WORD_WIDTH;

  state_e         state_q;
  egcd_t          tup_q;
  egcd_t          step_nxt;
  logic           step_r_zero;
  logic [W-1:0]   n_q;
  logic           illegal_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   inv_q;
  logic           err_q;
  logic           illegal_d;
  logic           fail_d;
  logic [W-1:0]   inv_d;
`ifdef MOD_INV_TIMEOUT_EN
  localparam int ITER_W = $clog2(MAX_ITER + 1);
  logic [ITER_W-1:0] iter_q;
  logic              timeout_q;
`endif

  egcd_step u_step (
    .cur_i    (tup_q),
    .nxt_o    (step_nxt),
    .r_zero_o (step_r_zero)
  );

  always_comb begin
    illegal_d = (bus.n_i < W'(2)) || (bus.a_i == '0) || (bus.a_i >= bus.n_i);
    fail_d    = illegal_q || (tup_q.old_r != W'(1));
`ifdef MOD_INV_TIMEOUT_EN
    fail_d    = fail_d || timeout_q;
`endif
    // Negative coefficient folds into [0, n-1]; modulo-2^W arithmetic is exact here.
    inv_d = tup_q.old_s[COEFF_W-1] ? (tup_q.old_s[W-1:0] + n_q) : tup_q.old_s[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tup_q     <= '0;
      n_q       <= '0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      inv_q     <= '0;
      err_q     <= 1'b0;
`ifdef MOD_INV_TIMEOUT_EN
      iter_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            n_q         <= bus.n_i;
            tup_q.old_r <= bus.n_i;
            tup_q.r     <= bus.a_i;
            tup_q.old_s <= '0;
            tup_q.s     <= COEFF_W'(1);
            illegal_q   <= illegal_d;
            busy_q      <= 1'b1;
            state_q     <= illegal_d ? FINAL : ITER;
`ifdef MOD_INV_TIMEOUT_EN
            iter_q      <= '0;
            timeout_q   <= 1'b0;
`endif
          end
        end
        ITER: begin
          tup_q <= step_nxt;
          if (step_r_zero) begin
            state_q <= FINAL;
          end
`ifdef MOD_INV_TIMEOUT_EN
          else if (iter_q == ITER_W'(MAX_ITER - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= FINAL;
          end
          iter_q <= iter_q + ITER_W'(1);
`endif
        end
        FINAL: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          inv_q   <= fail_d ? '0 : inv_d;
          err_q   <= fail_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.inv_o   = inv_q;
  assign bus.error_o = err_q;
  assign dbg_state_o = state_q;
endmodule
